// File: rtl/equeue_collapse_if.sv
// equeue_collapse_if: dispatch, CDB broadcast and issue signals of the collapsing issue queue.
// The master drives dispatch/CDB/issue_done; the slave is the queue itself.
interface equeue_collapse_if #(
    parameter int DEPTH  = 8,
    parameter int OPC_W  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int N_CDB  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [OPC_W-1:0]        dispatch_opcode;
    logic [TAG_W-1:0]        dispatch_rdtag;
    logic [TAG_W-1:0]        dispatch_rstag;
    logic [TAG_W-1:0]        dispatch_rttag;
    logic [DATA_W-1:0]       dispatch_rsdata;
    logic [DATA_W-1:0]       dispatch_rtdata;
    logic                    dispatch_rsvalid;
    logic                    dispatch_rtvalid;
    logic                    dispatch_en;
    logic                    dispatch_ready;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_data;
    logic [N_CDB-1:0]        cdb_valid;
    logic [OPC_W-1:0]        issue_opcode;
    logic [TAG_W-1:0]        issue_rdtag;
    logic [DATA_W-1:0]       issue_rsdata;
    logic [DATA_W-1:0]       issue_rtdata;
    logic                    issue_ready;
    logic                    issue_done;
    logic [CNT_W-1:0]        occupancy;
    modport master (
        output dispatch_opcode, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
               dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
               dispatch_en, cdb_tag, cdb_data, cdb_valid, issue_done,
        input  dispatch_ready, issue_opcode, issue_rdtag, issue_rsdata, issue_rtdata,
               issue_ready, occupancy
    );
    modport slave (
        input  dispatch_opcode, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
               dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
               dispatch_en, cdb_tag, cdb_data, cdb_valid, issue_done,
        output dispatch_ready, issue_opcode, issue_rdtag, issue_rsdata, issue_rtdata,
               issue_ready, occupancy
    );
endinterface

// File: rtl/equeue_collapse.sv
// equeue_collapse: parametrised collapsing out-of-order issue queue with N-channel CDB wakeup.
// Defining EQUEUE_FLUSH_EN adds a flush input that empties the queue at the next edge.
module equeue_collapse #(
    parameter int DEPTH  = 8,
    parameter int OPC_W  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int N_CDB  = 2
) (
    input logic clk,
    input logic reset,
`ifdef EQUEUE_FLUSH_EN
    input logic flush,
`endif
    equeue_collapse_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rst;
        logic [TAG_W-1:0]  rtt;
        logic [DATA_W-1:0] rsd;
        logic [DATA_W-1:0] rtd;
        logic              rsv;
        logic              rtv;
    } entry_t;
    entry_t           ent [DEPTH];
    entry_t           ent_nx [DEPTH];
    entry_t           woke [DEPTH+1];
    entry_t           din;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] wr;
    logic [IDX_W-1:0] sel;
    logic             any;
    logic             flush_i;
    logic             do_iss;
    logic             acc;
`ifdef EQUEUE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif
    // Scan downward so the lowest matching channel is the one that sticks.
    function automatic entry_t wake(input entry_t e, input logic [N_CDB-1:0] cv,
                                    input logic [N_CDB*TAG_W-1:0] ct,
                                    input logic [N_CDB*DATA_W-1:0] cd);
        entry_t r;
        r = e;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (!e.rsv && cv[k] && ct[k*TAG_W +: TAG_W] == e.rst) begin
                r.rsv = 1'b1;
                r.rsd = cd[k*DATA_W +: DATA_W];
            end
            if (!e.rtv && cv[k] && ct[k*TAG_W +: TAG_W] == e.rtt) begin
                r.rtv = 1'b1;
                r.rtd = cd[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction
    assign din = '{opc: bus.dispatch_opcode, rd: bus.dispatch_rdtag,
                   rst: bus.dispatch_rstag, rtt: bus.dispatch_rttag,
                   rsd: bus.dispatch_rsdata, rtd: bus.dispatch_rtdata,
                   rsv: bus.dispatch_rsvalid, rtv: bus.dispatch_rtvalid};
    always_comb begin
        any = 1'b0;
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < int'(occ) && ent[i].rsv && ent[i].rtv) begin
                any = 1'b1;
                sel = IDX_W'(i);
            end
        end
    end
    assign bus.issue_ready    = any & ~flush_i;
    assign do_iss             = bus.issue_ready & bus.issue_done;
    assign bus.dispatch_ready = ~flush_i & ((occ < CNT_W'(DEPTH)) | do_iss);
    assign acc                = bus.dispatch_en & bus.dispatch_ready;
    assign wr                 = occ - CNT_W'(do_iss);
    assign bus.issue_opcode   = bus.issue_ready ? ent[sel].opc : '0;
    assign bus.issue_rdtag    = bus.issue_ready ? ent[sel].rd  : '0;
    assign bus.issue_rsdata   = bus.issue_ready ? ent[sel].rsd : '0;
    assign bus.issue_rtdata   = bus.issue_ready ? ent[sel].rtv ? ent[sel].rtd : '0 : '0;
    assign bus.occupancy      = occ;
    // Slots at and above the issued one take their younger neighbour; the top slot is filled with zeros.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            woke[i] = wake(ent[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        woke[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_nx[i] = (do_iss && i >= int'(sel)) ? woke[i+1] : woke[i];
            if (acc && int'(wr) == i)
                ent_nx[i] = wake(din, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            if (flush_i)
                ent_nx[i] = '0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= '0;
            occ <= '0;
        end else begin
            ent <= ent_nx;
            occ <= flush_i ? '0 : wr + CNT_W'(acc);
        end
    end
endmodule

// File: tb/tb_equeue_collapse.sv
// tb_equeue_collapse: randomized scoreboard bench for equeue_collapse against a queue-based reference model.
// Directed sequences cover reset, ordering, wakeup, dispatch-cycle capture, full queue and mid-run reset.
module tb_equeue_collapse;
    localparam int DEPTH  = 8;
    localparam int OPC_W  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int N_CDB  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rst;
        logic [TAG_W-1:0]  rtt;
        logic [DATA_W-1:0] rsd;
        logic [DATA_W-1:0] rtd;
        logic              rsv;
        logic              rtv;
    } m_ent_t;
    typedef struct packed {
        logic [CNT_W-1:0] occ;
        logic             dr;
        logic             ir;
    } rec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int checks = 0;
    int passed = 0;
    m_ent_t mq[$];
    m_ent_t exp_q[$];
    rec_t   cyc_q[$];
    always #5 clk = ~clk;
    equeue_collapse_if #(.DEPTH(DEPTH), .OPC_W(OPC_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB)) bus ();
    equeue_collapse #(.DEPTH(DEPTH), .OPC_W(OPC_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB)) dut (
        .clk(clk),
        .reset(reset),
`ifdef EQUEUE_FLUSH_EN
        .flush(flush),
`endif
        .bus(bus)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    function automatic m_ent_t mk(input int opc, input int rd, input int rst, input logic rsv,
                                  input int rsd, input int rtt, input logic rtv, input int rtd);
        m_ent_t e;
        e.opc = OPC_W'(opc); e.rd = TAG_W'(rd);
        e.rst = TAG_W'(rst); e.rsv = rsv; e.rsd = DATA_W'(rsd);
        e.rtt = TAG_W'(rtt); e.rtv = rtv; e.rtd = DATA_W'(rtd);
        return e;
    endfunction
    // Reference wakeup: first channel (lowest index) carrying the awaited tag supplies the value.
    function automatic m_ent_t wake(input m_ent_t e, input logic [N_CDB-1:0] cv,
                                    input logic [N_CDB*TAG_W-1:0] ct, input logic [N_CDB*DATA_W-1:0] cd);
        m_ent_t r = e;
        for (int k = 0; k < N_CDB; k++) begin
            if (!r.rsv && cv[k] && ct[k*TAG_W +: TAG_W] == e.rst) begin
                r.rsv = 1'b1; r.rsd = cd[k*DATA_W +: DATA_W];
            end
            if (!r.rtv && cv[k] && ct[k*TAG_W +: TAG_W] == e.rtt) begin
                r.rtv = 1'b1; r.rtd = cd[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction
    task automatic cyc(input logic en, input m_ent_t d, input logic done, input logic [N_CDB-1:0] cv,
                       input logic [N_CDB*TAG_W-1:0] ct, input logic [N_CDB*DATA_W-1:0] cd, input logic fl);
        int sel;
        logic ir, iss, dr, fe;
        rec_t r;
        @(posedge clk);
        #2;
        bus.dispatch_en = en; bus.dispatch_opcode = d.opc; bus.dispatch_rdtag = d.rd;
        bus.dispatch_rstag = d.rst; bus.dispatch_rttag = d.rtt;
        bus.dispatch_rsdata = d.rsd; bus.dispatch_rtdata = d.rtd;
        bus.dispatch_rsvalid = d.rsv; bus.dispatch_rtvalid = d.rtv;
        bus.issue_done = done; bus.cdb_valid = cv; bus.cdb_tag = ct; bus.cdb_data = cd;
        flush = fl;
`ifdef EQUEUE_FLUSH_EN
        fe = fl;
`else
        fe = 1'b0;
`endif
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].rsv && mq[i].rtv) sel = i;
        ir = (sel >= 0) && !fe;
        iss = ir && done;
        dr = !fe && (mq.size() < DEPTH || iss);
        r.occ = CNT_W'(mq.size()); r.dr = dr; r.ir = ir;
        cyc_q.push_back(r);
        if (iss) begin
            exp_q.push_back(mq[sel]);
            mq.delete(sel);
        end
        foreach (mq[i]) mq[i] = wake(mq[i], cv, ct, cd);
        if (en && dr) mq.push_back(wake(d, cv, cd == '0 ? ct : ct, cd));
        if (fe) mq.delete();
    endtask
    task automatic idle(input logic done);
        cyc(1'b0, '0, done, '0, '0, '0, 1'b0);
    endtask
    task automatic rand_cyc();
        logic [N_CDB*TAG_W-1:0] ct;
        logic [N_CDB*DATA_W-1:0] cd;
        m_ent_t d;
        for (int k = 0; k < N_CDB; k++) begin
            ct[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
            cd[k*DATA_W +: DATA_W] = $urandom;
        end
        d = mk($urandom, $urandom, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom);
        cyc(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 3) != 0),
            N_CDB'($urandom), ct, cd, 1'($urandom_range(0, 63) == 0));
    endtask
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.dispatch_en = 1'b0; bus.issue_done = 1'b0; bus.cdb_valid = '0; flush = 1'b0;
        mq.delete(); exp_q.delete(); cyc_q.delete();
        #1;
        chk("rst_occupancy", 64'(bus.occupancy), 0);
        chk("rst_issue_ready", 64'(bus.issue_ready), 0);
        chk("rst_issue_fields", {bus.issue_opcode, bus.issue_rdtag, bus.issue_rsdata}, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_dispatch_ready", 64'(bus.dispatch_ready), 1);
        chk("rst_issue_rtdata", 64'(bus.issue_rtdata), 0);
    endtask
    initial begin : monitor
        rec_t r;
        m_ent_t e;
        forever begin
            @(negedge clk);
            if (reset && cyc_q.size() > 0) begin
                r = cyc_q.pop_front();
                chk("occupancy", 64'(bus.occupancy), 64'(r.occ));
                chk("dispatch_ready", 64'(bus.dispatch_ready), 64'(r.dr));
                chk("issue_ready", 64'(bus.issue_ready), 64'(r.ir));
                if (bus.issue_ready && bus.issue_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL issue_unexpected: got rdtag %0h expected no issue", bus.issue_rdtag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("issue_rdtag", 64'(bus.issue_rdtag), 64'(e.rd));
                        chk("issue_opcode", 64'(bus.issue_opcode), 64'(e.opc));
                        chk("issue_rsdata", 64'(bus.issue_rsdata), 64'(e.rsd));
                        chk("issue_rtdata", 64'(bus.issue_rtdata), 64'(e.rtd));
                    end
                end else if (!bus.issue_ready) begin
                    chk("idle_issue_zero", {bus.issue_opcode, bus.issue_rdtag, bus.issue_rsdata ^ bus.issue_rtdata}, 0);
                end
            end
        end
    end
    initial begin : driver
        bus.dispatch_en = 1'b0; bus.issue_done = 1'b0; bus.cdb_valid = '0;
        bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.dispatch_opcode = '0; bus.dispatch_rdtag = '0; bus.dispatch_rstag = '0; bus.dispatch_rttag = '0;
        bus.dispatch_rsdata = '0; bus.dispatch_rtdata = '0; bus.dispatch_rsvalid = 1'b0; bus.dispatch_rtvalid = 1'b0;
        do_reset();
        for (int i = 5; i <= 7; i++) cyc(1'b1, mk(i, i, 0, 1, 'h100 + i, 0, 1, 'h200 + i), 1'b1, '0, '0, '0, 1'b0);
        repeat (3) idle(1'b1);
        cyc(1'b1, mk(1, 9, 12, 0, 0, 1, 1, 'h11), 1'b1, '0, '0, '0, 1'b0);
        cyc(1'b1, mk(2, 10, 1, 1, 'h22, 1, 1, 'h33), 1'b1, 2'b10, {TAG_W'(12), TAG_W'(0)}, {32'hDEAD, 32'h0}, 1'b0);
        repeat (3) idle(1'b1);
        cyc(1'b1, mk(3, 4, 3, 0, 0, 2, 1, 'h44), 1'b1, 2'b01, {TAG_W'(0), TAG_W'(3)}, {32'h0, 32'h55}, 1'b0);
        repeat (2) idle(1'b1);
        cyc(1'b1, mk(4, 8, 5, 0, 0, 5, 0, 0), 1'b1, 2'b11, {TAG_W'(5), TAG_W'(5)}, {32'hB1, 32'hA0}, 1'b0);
        repeat (2) idle(1'b1);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, mk(i, 20 + i, 0, 1, i, 0, 1, i), 1'b0, '0, '0, '0, 1'b0);
        cyc(1'b1, mk(7, 40, 0, 1, 7, 0, 1, 7), 1'b1, '0, '0, '0, 1'b0);
        repeat (DEPTH + 2) idle(1'b1);
        for (int i = 0; i < 600; i++) rand_cyc();
        do_reset();
        for (int i = 0; i < 1200; i++) rand_cyc();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        chk("records_drained", 64'(cyc_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
